// File: rtl/btn_pkg.sv
// Shared types and 12 MHz default timing for the push-button front end.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESSED,
    REPEAT
  } btn_state_t;

  localparam int BTN_DEBOUNCE_CYCLES = 240_000;
  localparam int BTN_HOLD_CYCLES     = 6_000_000;
  localparam int BTN_REPEAT_CYCLES   = 1_200_000;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous board inputs.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;

  always_comb begin
    sync1_d = d;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign q = sync2_q;

endmodule

// File: rtl/btn_conditioner.sv
// Push-button conditioner: sync, debounce, press/release events and
// auto-repeat step stream for the digit counter.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = BTN_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = BTN_HOLD_CYCLES,
  parameter int REPEAT_CYCLES   = BTN_REPEAT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic step_pulse,
  output logic long_hold
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW = $clog2(HOLD_CYCLES);
  localparam int RW = $clog2(REPEAT_CYCLES);
  localparam logic [DW-1:0] DEB_MAX  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES - 1);
  localparam logic [RW-1:0] REP_MAX  = RW'(REPEAT_CYCLES - 1);

  logic btn_sync;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_raw),
    .q   (btn_sync)
  );

  btn_state_t    state_q, state_d;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [RW-1:0] rep_cnt_q, rep_cnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          step_q, step_d;
  logic          long_hold_q, long_hold_d;
  logic          rise, fall;

  always_comb begin
    deb_cnt_d = deb_cnt_q;
    level_d   = level_q;
    rise      = 1'b0;
    fall      = 1'b0;
    if (btn_sync == level_q) begin
      deb_cnt_d = '0;
    end else if (deb_cnt_q == DEB_MAX) begin
      level_d   = btn_sync;
      deb_cnt_d = '0;
      rise      = btn_sync;
      fall      = ~btn_sync;
    end else begin
      deb_cnt_d = deb_cnt_q + 1'b1;
    end
  end

  // An accepted fall always beats a coincident hold/repeat expiry.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    rep_cnt_d  = rep_cnt_q;
    press_d    = 1'b0;
    release_d  = 1'b0;
    step_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rise) begin
          state_d    = PRESSED;
          hold_cnt_d = '0;
          press_d    = 1'b1;
          step_d     = 1'b1;
        end
      end
      PRESSED: begin
        if (fall) begin
          state_d   = IDLE;
          release_d = 1'b1;
        end else if (hold_cnt_q == HOLD_MAX) begin
          state_d   = REPEAT;
          step_d    = 1'b1;
          rep_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      REPEAT: begin
        if (fall) begin
          state_d   = IDLE;
          release_d = 1'b1;
        end else if (rep_cnt_q == REP_MAX) begin
          step_d    = 1'b1;
          rep_cnt_d = '0;
        end else begin
          rep_cnt_d = rep_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    long_hold_d = (state_d == REPEAT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      deb_cnt_q   <= '0;
      hold_cnt_q  <= '0;
      rep_cnt_q   <= '0;
      level_q     <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      step_q      <= 1'b0;
      long_hold_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      deb_cnt_q   <= deb_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      rep_cnt_q   <= rep_cnt_d;
      level_q     <= level_d;
      press_q     <= press_d;
      release_q   <= release_d;
      step_q      <= step_d;
      long_hold_q <= long_hold_d;
    end
  end

  assign btn_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign step_pulse    = step_q;
  assign long_hold     = long_hold_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench for btn_conditioner with short debounce/hold/repeat.
module tb_btn_conditioner;

  localparam int DEB  = 4;
  localparam int HOLD = 10;
  localparam int REP  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_raw = 1'b1;
  logic btn_level, press_pulse, release_pulse, step_pulse, long_hold;

  typedef struct {
    int   cyc;
    logic pr;
    logic rl;
    logic st;
    logic lh;
  } ev_t;

  ev_t  sb_q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;
  logic exp_lvl = 1'b0;
  logic exp_lh = 1'b0;

  btn_conditioner #(
    .DEBOUNCE_CYCLES (DEB),
    .HOLD_CYCLES     (HOLD),
    .REPEAT_CYCLES   (REP)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .btn_raw       (btn_raw),
    .btn_level     (btn_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .step_pulse    (step_pulse),
    .long_hold     (long_hold)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h",
               tag, cyc, got, exp);
    end
  endtask

  function automatic ev_t mk(input int c, input logic pr, input logic rl,
                             input logic st, input logic lh);
    ev_t e;
    e.cyc = c;
    e.pr  = pr;
    e.rl  = rl;
    e.st  = st;
    e.lh  = lh;
    return e;
  endfunction

  // raw rises at negedge c (first sampled at edge c+1), falls len later
  task automatic sched(input int c, input int len);
    int p, r, t;
    p = c + DEB + 2;
    r = c + len + DEB + 2;
    sb_q.push_back(mk(p, 1'b1, 1'b0, 1'b1, 1'b0));
    t = p + HOLD;
    if (t < r) sb_q.push_back(mk(t, 1'b0, 1'b0, 1'b1, 1'b1));
    t += REP;
    while (t < r) begin
      sb_q.push_back(mk(t, 1'b0, 1'b0, 1'b1, 1'b0));
      t += REP;
    end
    sb_q.push_back(mk(r, 1'b0, 1'b1, 1'b0, 1'b0));
  endtask

  task automatic do_press(input int len);
    int c;
    c = cyc;
    btn_raw = 1'b1;
    sched(c, len);
    repeat (len) @(negedge clk);
    btn_raw = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  always @(negedge clk) begin : mon
    ev_t e;
    if (cyc >= 1) begin
      e = mk(0, 1'b0, 1'b0, 1'b0, 1'b0);
      while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
        chk("sb_late", sb_q[0].cyc, cyc);
        void'(sb_q.pop_front());
      end
      if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
        e = sb_q.pop_front();
        if (e.pr) exp_lvl = 1'b1;
        if (e.rl) begin
          exp_lvl = 1'b0;
          exp_lh  = 1'b0;
        end
        if (e.lh) exp_lh = 1'b1;
      end
      chk(rst ? "reset_state" : "lvl_pr_rl_st_lh",
          {27'd0, btn_level, press_pulse, release_pulse,
           step_pulse, long_hold},
          {27'd0, exp_lvl, e.pr, e.rl, e.st, exp_lh});
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    // button held through reset: fresh press after release of rst
    do_press(8);
    do_press(8);
    // glitch: 3 high, 1 low, 3 high, low
    btn_raw = 1'b1;
    repeat (3) @(negedge clk);
    btn_raw = 1'b0;
    @(negedge clk);
    btn_raw = 1'b1;
    repeat (3) @(negedge clk);
    btn_raw = 1'b0;
    repeat (12) @(negedge clk);
    do_press(30);
    // release on repeat wrap, then on hold expiry
    do_press(HOLD + 3 * REP);
    do_press(HOLD);
    do_press(HOLD + 1);
    repeat (4) @(negedge clk);
    chk("sb_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
